// File: rtl/nibble_serializer_16_to_4.sv
// Serializes one 16-bit word per handshake into a stream of 4-bit nibbles.
// The last nibble of each word is tagged; zero-extended nibbles may be sent as one.
module nibble_serializer_16_to_4 #(
    parameter int MSB_FIRST    = 0,
    parameter int SKIP_ZERO_HI = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  out_nibble,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t      state, state_next;
    logic [15:0] sreg;
    logic [2:0]  count;
    logic        accept, xfer, load_skip;
    logic [15:0] load_val;

    assign xfer      = out_valid & out_ready;
    assign accept    = in_valid & in_ready;
    assign load_skip = (SKIP_ZERO_HI != 0) && (in_word[15:4] == 12'h000);

    // A skipped word is placed where the output tap looks, so it emits [3:0] in either order.
    always_comb begin
        load_val = in_word;
        if (load_skip)
            load_val = (MSB_FIRST != 0) ? {in_word[3:0], 12'h000} : {12'h000, in_word[3:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SEND;
            SEND:    if (xfer && out_last && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid  = (state == SEND);
        busy       = (state == SEND);
        out_last   = (state == SEND) && (count == 3'd1);
        in_ready   = (state == IDLE) || (xfer && out_last);
        out_nibble = (MSB_FIRST != 0) ? sreg[15:12] : sreg[3:0];
    end

    // After the last nibble leaves without a reload, sreg is left alone so out_nibble holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg  <= 16'h0000;
            count <= 3'd0;
        end else if (accept) begin
            sreg  <= load_val;
            count <= load_skip ? 3'd1 : 3'd4;
        end else if (xfer && !out_last) begin
            sreg  <= (MSB_FIRST != 0) ? {sreg[11:0], 4'h0} : {4'h0, sreg[15:4]};
            count <= count - 3'd1;
        end
    end
endmodule
